// File: rtl/nx_mimosa_v40_pkg.sv
// Shared types and register map for the classifier feature AXI-Lite block.
package nx_mimosa_v40_pkg;

    // Snapshot produced by the feature extractor; Q16.16 fields are carried raw.
    typedef struct packed {
        logic [31:0] spd_avg;
        logic [31:0] omega_peak;
        logic [31:0] omega_avg;
        logic [31:0] nis_cv_avg;
        logic [31:0] nis_cv_peak;
        logic [31:0] mu_ct_peak;
        logic [31:0] mu_ca_peak;
        logic        is_maneuvering;
        logic        is_high_dynamics;
    } classifier_features_t;

    typedef struct packed {
        classifier_features_t f;
        logic [15:0]          seq;
    } feat_entry_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] conf;
    } platform_result_t;

    typedef enum logic [0:0] {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte offsets; bits [1:0] of the bus address are ignored.
    localparam int unsigned REG_STATUS      = 32'h00;
    localparam int unsigned REG_CTRL        = 32'h04;
    localparam int unsigned REG_SPD_AVG     = 32'h08;
    localparam int unsigned REG_OMEGA_PEAK  = 32'h0C;
    localparam int unsigned REG_OMEGA_AVG   = 32'h10;
    localparam int unsigned REG_NIS_CV_AVG  = 32'h14;
    localparam int unsigned REG_NIS_CV_PEAK = 32'h18;
    localparam int unsigned REG_MU_CT_PEAK  = 32'h1C;
    localparam int unsigned REG_MU_CA_PEAK  = 32'h20;
    localparam int unsigned REG_FLAGS       = 32'h24;
    localparam int unsigned REG_RESULT      = 32'h28;
    localparam int unsigned REG_END         = 32'h2C;

endpackage

// File: rtl/nx_mimosa_v40_feat_fifo.sv
// Snapshot FIFO. A pop is applied before a push, so a full FIFO that is
// popped and pushed in the same cycle accepts the new entry.
module nx_mimosa_v40_feat_fifo
    import nx_mimosa_v40_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  feat_entry_t                   din,
    output feat_entry_t                   head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          accepted,
    output logic                          dropped
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    feat_entry_t   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop_ok   = pop && !empty;
    assign accepted = push && (!full || pop_ok);
    assign dropped  = push && full && !pop_ok;
    assign head     = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
            if (accepted && !pop_ok)      count <= count + 1'b1;
            else if (!accepted && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/nx_mimosa_v40_feature_axil.sv
// AXI-Lite slave buffering classifier feature snapshots for the PS and
// returning the platform-ID result to the PL as a one-cycle pulse.
// Optional: define NX_MIMOSA_FEAT_IRQ_EN to add the irq output and STATUS[11].
module nx_mimosa_v40_feature_axil
    import nx_mimosa_v40_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IRQ_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  classifier_features_t features,
    input  logic                 features_valid,
    input  logic [ADDR_W-1:0]    s_axil_awaddr,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,
    input  logic [31:0]          s_axil_wdata,
    input  logic [3:0]           s_axil_wstrb,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,
    output logic [1:0]           s_axil_bresp,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,
    input  logic [ADDR_W-1:0]    s_axil_araddr,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    output logic [31:0]          s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic [7:0]           platform_id,
    output logic [15:0]          platform_conf,
`ifdef NX_MIMOSA_FEAT_IRQ_EN
    output logic                 irq,
`endif
    output logic                 platform_valid
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    w_state_t         w_state_q, w_state_d;
    r_state_t         r_state_q, r_state_d;
    logic             ready_en_q;
    logic [15:0]      seq_q;
    logic [15:0]      drop_cnt_q;
    logic             overflow_q;
    platform_result_t result_q;
    logic             platform_valid_q;
    logic             irq_bit;

    logic [31:0]      aw_off;
    logic [31:0]      ar_off;
    logic             aw_acc;
    logic             ar_acc;
    logic             ctrl_pop;
    logic             ctrl_clr;
    logic             result_wr;
    logic [1:0]       bresp_d;
    logic [31:0]      rd_data_d;
    logic [1:0]       rd_resp_d;
    logic [31:0]      status_word;

    feat_entry_t      fifo_din;
    feat_entry_t      head;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             dropped;

    logic             unused_bits;
    assign unused_bits = ^{s_axil_wdata[31:24], s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign aw_off = 32'({s_axil_awaddr[ADDR_W-1:2], 2'b00});
    assign ar_off = 32'({s_axil_araddr[ADDR_W-1:2], 2'b00});

    assign fifo_din = '{f: features, seq: seq_q};

    nx_mimosa_v40_feat_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (features_valid),
        .pop      (ctrl_pop),
        .din      (fifo_din),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .accepted (push_ok),
        .dropped  (dropped)
    );

    // Write channel FSM: AW and W must arrive together, then one B beat.
    always_comb begin
        w_state_d      = w_state_q;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axil_awready = ready_en_q;
                s_axil_wready  = ready_en_q;
                if (ready_en_q && s_axil_awvalid && s_axil_wvalid) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign aw_acc = s_axil_awready && s_axil_awvalid && s_axil_wvalid;

    // Write decode: CTRL ignores wstrb, RESULT needs a full-word strobe.
    always_comb begin
        ctrl_pop  = 1'b0;
        ctrl_clr  = 1'b0;
        result_wr = 1'b0;
        bresp_d   = RESP_OKAY;
        if (aw_acc) begin
            if (aw_off >= REG_END) begin
                bresp_d = RESP_SLVERR;
            end else if (aw_off == REG_CTRL) begin
                ctrl_pop = s_axil_wdata[0];
                ctrl_clr = s_axil_wdata[1];
            end else if (aw_off == REG_RESULT && s_axil_wstrb == 4'hF) begin
                result_wr = 1'b1;
            end
        end
    end

    // Read channel FSM: data registered at AR acceptance, held until rready.
    always_comb begin
        r_state_d      = r_state_q;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axil_arready = ready_en_q;
                if (ready_en_q && s_axil_arvalid) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign ar_acc = s_axil_arready && s_axil_arvalid;

    assign status_word = {drop_cnt_q, 4'b0, irq_bit, overflow_q, full, empty, 3'b0,
                          5'(count)};

    // Read decode; FIFO-backed registers read 0 while empty.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        case (ar_off)
            REG_STATUS:      rd_data_d = status_word;
            REG_CTRL:        rd_data_d = '0;
            REG_SPD_AVG:     if (!empty) rd_data_d = head.f.spd_avg;
            REG_OMEGA_PEAK:  if (!empty) rd_data_d = head.f.omega_peak;
            REG_OMEGA_AVG:   if (!empty) rd_data_d = head.f.omega_avg;
            REG_NIS_CV_AVG:  if (!empty) rd_data_d = head.f.nis_cv_avg;
            REG_NIS_CV_PEAK: if (!empty) rd_data_d = head.f.nis_cv_peak;
            REG_MU_CT_PEAK:  if (!empty) rd_data_d = head.f.mu_ct_peak;
            REG_MU_CA_PEAK:  if (!empty) rd_data_d = head.f.mu_ca_peak;
            REG_FLAGS: begin
                if (!empty) begin
                    rd_data_d = {head.seq, 14'b0, head.f.is_high_dynamics,
                                 head.f.is_maneuvering};
                end
            end
            REG_RESULT:      rd_data_d = {8'h00, result_q.conf, result_q.id};
            default:         rd_resp_d = RESP_SLVERR;
        endcase
    end

    // FSM state, bus response registers and ready gating after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            ready_en_q   <= 1'b0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rdata <= '0;
            s_axil_rresp <= RESP_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            ready_en_q <= 1'b1;
            if (aw_acc) s_axil_bresp <= bresp_d;
            if (ar_acc) begin
                s_axil_rdata <= rd_data_d;
                s_axil_rresp <= rd_resp_d;
            end
        end
    end

    // Sequence number, overflow tracking and the PS result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q            <= '0;
            overflow_q       <= 1'b0;
            drop_cnt_q       <= '0;
            result_q         <= '0;
            platform_valid_q <= 1'b0;
        end else begin
            if (push_ok) seq_q <= seq_q + 16'd1;
            if (ctrl_clr) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (dropped) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (result_wr) begin
                result_q.id   <= s_axil_wdata[7:0];
                result_q.conf <= s_axil_wdata[23:8];
            end
            platform_valid_q <= result_wr;
        end
    end

    assign platform_id    = result_q.id;
    assign platform_conf  = result_q.conf;
    assign platform_valid = platform_valid_q;

`ifdef NX_MIMOSA_FEAT_IRQ_EN
    logic irq_q;

    // Interrupt level, registered from current occupancy and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (32'(count) >= IRQ_THRESH) || overflow_q;
    end

    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    logic unused_irq_thresh;
    assign unused_irq_thresh = (IRQ_THRESH == 32'd0);
    assign irq_bit           = 1'b0;
`endif

endmodule

// File: tb/tb_nx_mimosa_v40_feature_axil.sv
// Directed self-checking bench for nx_mimosa_v40_feature_axil (default build).
module tb_nx_mimosa_v40_feature_axil;
    import nx_mimosa_v40_pkg::*;

    localparam int unsigned ADDR_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    classifier_features_t features;
    logic                 features_valid;
    logic [ADDR_W-1:0]    awaddr;
    logic                 awvalid, awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid, wready;
    logic [1:0]           bresp;
    logic                 bvalid, bready;
    logic [ADDR_W-1:0]    araddr;
    logic                 arvalid, arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid, rready;
    logic [7:0]           platform_id;
    logic [15:0]          platform_conf;
    logic                 platform_valid;
`ifdef NX_MIMOSA_FEAT_IRQ_EN
    logic                 irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt   = 0;

    always #5 clk = ~clk;

    nx_mimosa_v40_feature_axil #(
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W),
        .IRQ_THRESH (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .features       (features),
        .features_valid (features_valid),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .platform_id    (platform_id),
        .platform_conf  (platform_conf),
`ifdef NX_MIMOSA_FEAT_IRQ_EN
        .irq            (irq),
`endif
        .platform_valid (platform_valid)
    );

    always @(negedge clk) if (platform_valid === 1'b1) pv_cnt++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic classifier_features_t make_feat(input int i);
        classifier_features_t f;
        f                  = '0;
        f.spd_avg          = 32'h100 + 32'(i);
        f.omega_peak       = 32'h200 + 32'(i);
        f.is_high_dynamics = i[0];
        return f;
    endfunction

    task automatic push(input classifier_features_t f);
        @(negedge clk);
        features       = f;
        features_valid = 1'b1;
        @(negedge clk);
        features_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic with_push,
                             input classifier_features_t f, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_w_ready", {31'b0, awready && wready}, 32'd1);
        if (with_push) begin
            features       = f;
            features_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        features_valid = 1'b0;
        bready         = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] resp,
                            output logic stable);
        int n;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready", {31'b0, arready}, 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rvalid", {31'b0, rvalid}, 32'd1);
        d      = rdata;
        resp   = rresp;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rvalid !== 1'b1 || rdata !== d || rresp !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        st;
        classifier_features_t f;

        rst_n          = 1'b0;
        features       = '0;
        features_valid = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        check("rst_platform", {7'b0, platform_valid, platform_conf, platform_id}, 32'd0);
        rst_n = 1'b1;

        axi_read(8'h00, 0, d, r, st);
        check("status_empty", d, 32'h0000_0100);
        check("status_rresp", {30'b0, r}, 32'd0);

        // Single snapshot push, readback and pop
        f = '0;
        f.spd_avg        = 32'h000A_0000;
        f.is_maneuvering = 1'b1;
        push(f);
        axi_read(8'h08, 0, d, r, st);
        check("spd_avg", d, 32'h000A_0000);
        axi_read(8'h24, 0, d, r, st);
        check("flags_first", d, 32'h0000_0001);
        axi_read(8'h00, 0, d, r, st);
        check("status_one", d, 32'h0000_0001);
        axi_write(8'h04, 32'h1, 4'hF, 1'b0, f, r);
        check("ctrl_bresp", {30'b0, r}, 32'd0);
        axi_read(8'h00, 0, d, r, st);
        check("status_popped", d, 32'h0000_0100);

        // Reset restarts seq; overfill a 4-deep FIFO with 6 snapshots
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) push(make_feat(i));
        axi_read(8'h00, 0, d, r, st);
        check("status_overflow", d, 32'h0002_0604);
        axi_read(8'h24, 0, d, r, st);
        check("head_flags_seq0", d, 32'h0000_0000);
        axi_read(8'h08, 0, d, r, st);
        check("head_spd", d, 32'h0000_0100);
        axi_read(8'h0C, 0, d, r, st);
        check("head_omega_peak", d, 32'h0000_0200);
        axi_write(8'h04, 32'h2, 4'h0, 1'b0, f, r);
        axi_read(8'h00, 0, d, r, st);
        check("status_cleared", d, 32'h0000_0204);

        // Full FIFO: CTRL pop coincident with a push
        axi_write(8'h04, 32'h1, 4'hF, 1'b1, make_feat(6), r);
        axi_read(8'h00, 0, d, r, st);
        check("status_pop_push", d, 32'h0000_0204);
        axi_read(8'h24, 0, d, r, st);
        check("head_after_pp", d, 32'h0001_0002);
        for (int i = 0; i < 3; i++) axi_write(8'h04, 32'h1, 4'hF, 1'b0, f, r);
        axi_read(8'h24, 0, d, r, st);
        check("tail_seq", d, 32'h0004_0000);
        axi_read(8'h08, 0, d, r, st);
        check("tail_spd", d, 32'h0000_0106);

        // Drain then pop while empty
        axi_write(8'h04, 32'h1, 4'hF, 1'b0, f, r);
        axi_write(8'h04, 32'h1, 4'hF, 1'b0, f, r);
        axi_read(8'h00, 0, d, r, st);
        check("status_drained", d, 32'h0000_0100);
        axi_read(8'h08, 0, d, r, st);
        check("empty_fifo_read", d, 32'h0);
        check("empty_fifo_rresp", {30'b0, r}, 32'd0);
        axi_read(8'h04, 0, d, r, st);
        check("ctrl_reads_zero", d, 32'h0);

        // RESULT write and platform pulse
        pv_cnt = 0;
        axi_write(8'h28, 32'h0080_0007, 4'hF, 1'b0, f, r);
        repeat (3) @(negedge clk);
        check("platform_id", {24'b0, platform_id}, 32'h07);
        check("platform_conf", {16'b0, platform_conf}, 32'h8000);
        check("platform_pulse", 32'(pv_cnt), 32'd1);
        axi_read(8'h28, 0, d, r, st);
        check("result_read", d, 32'h0080_0007);
        axi_write(8'h28, 32'h0012_3456, 4'h3, 1'b0, f, r);
        repeat (3) @(negedge clk);
        check("partial_bresp", {30'b0, r}, 32'd0);
        check("partial_id", {24'b0, platform_id}, 32'h07);
        check("partial_pulse", 32'(pv_cnt), 32'd1);

        // Unmapped accesses
        axi_write(8'h2C, 32'hFFFF_FFFF, 4'hF, 1'b0, f, r);
        check("unmapped_bresp", {30'b0, r}, 32'd2);
        axi_read(8'h30, 5, d, r, st);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rresp", {30'b0, r}, 32'd2);
        check("unmapped_stable", {31'b0, st}, 32'd1);
        axi_read(8'h00, 0, d, r, st);
        check("status_final", d, 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
